// File: rtl/decode_regbank_pkg.sv
// Shared defaults and types for the decode-stage register bank and its scoreboard.
package decode_regbank_pkg;

    localparam int DEF_NREAD    = 2;
    localparam int DEF_NWRITE   = 1;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_PEND_W   = 2;
    localparam int DEF_ZERO_REG = 1;

    // In-flight write counter at the default width.
    typedef logic [DEF_PEND_W-1:0] pend_t;

endpackage

// File: rtl/decode_regbank_scoreboard.sv
// Per-register in-flight write counters plus source/structural hazard detection.
module decode_regbank_scoreboard
    import decode_regbank_pkg::*;
#(
    parameter int NREAD    = DEF_NREAD,
    parameter int NWRITE   = DEF_NWRITE,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic [NREAD-1:0]         ruse,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    output logic                     stall,
    output logic                     issue_accept,
    output logic                     sb_err
);

    localparam int NREG  = 2**ADDR_W;
    localparam int DEC_W = $clog2(NWRITE + 1);
    localparam int CNT_W = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;

    logic [PEND_W-1:0] r_pending     [NREG];
    logic [PEND_W-1:0] w_pending_nxt [NREG];
    logic [DEC_W-1:0]  w_dec         [NREG];
    logic              r_sb_err;
    logic              w_err;
    logic              w_src_hazard;
    logic              w_struct_hazard;
    logic              w_inc_en;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [ADDR_W-1:0] waddr_at(input int p);
        return waddr[p*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] raddr_at(input int p);
        return raddr[p*ADDR_W +: ADDR_W];
    endfunction

    // Number of retire ports targeting each register this cycle.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
            w_dec[i] = '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && (waddr_at(p) == ADDR_W'(i)) && !is_zero(waddr_at(p)))
                    w_dec[i] = w_dec[i] + DEC_W'(1);
            end
        end
    end

    always_comb begin
        w_src_hazard = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (ruse[p] && (CNT_W'(r_pending[raddr_at(p)]) > CNT_W'(w_dec[raddr_at(p)])))
                w_src_hazard = 1'b1;
        end
        w_struct_hazard = issue_we && !is_zero(issue_dest)
                       && (&r_pending[issue_dest]) && (w_dec[issue_dest] == '0);
        stall        = issue_valid && !flush && (w_src_hazard || w_struct_hazard);
        issue_accept = issue_valid && !stall;
        w_inc_en     = issue_accept && issue_we && !flush && !is_zero(issue_dest);
    end

    // A retire beyond the outstanding count is a scoreboard error; the counter floors at 0.
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (CNT_W'(w_dec[i]) > CNT_W'(r_pending[i])) begin
                w_err            = 1'b1;
                w_pending_nxt[i] = PEND_W'(w_inc_en && (issue_dest == ADDR_W'(i)));
            end else begin
                w_pending_nxt[i] = r_pending[i] - PEND_W'(w_dec[i])
                                 + PEND_W'(w_inc_en && (issue_dest == ADDR_W'(i)));
            end
            if (flush)
                w_pending_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_pending[i] <= '0;
            r_sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                r_pending[i] <= w_pending_nxt[i];
            if (w_err)
                r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

endmodule

// File: rtl/decode_regbank.sv
// Decode-stage register file with retire bypass, hi/lo registers and an issue scoreboard.
module decode_regbank
    import decode_regbank_pkg::*;
#(
    parameter int NREAD    = DEF_NREAD,
    parameter int NWRITE   = DEF_NWRITE,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic [NREAD-1:0]         ruse,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    output logic                     stall,
    output logic                     issue_accept,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata,
    input  logic                     flush,
    input  logic                     write_hi,
    input  logic                     write_lo,
    input  logic [DATA_W-1:0]        hi_din,
    input  logic [DATA_W-1:0]        lo_din,
    output logic [DATA_W-1:0]        hi,
    output logic [DATA_W-1:0]        lo,
    output logic                     sb_err
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // NOTE: the array is reset so every index reads 0 right after reset; this is a deliberate requirement, not a default for memories.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_mem[i] <= '0;
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            // NOTE: non-blocking writes; on an index collision the later (higher) port's update is the one that lands.
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && !is_zero(waddr[p*ADDR_W +: ADDR_W]))
                    r_mem[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
            end
            if (write_hi) r_hi <= hi_din;
            if (write_lo) r_lo <= lo_din;
        end
    end

    // Read with same-cycle retire bypass; the highest matching port is applied last.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < NREAD; r++) begin
            rdata[r*DATA_W +: DATA_W] = r_mem[raddr[r*ADDR_W +: ADDR_W]];
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && (waddr[p*ADDR_W +: ADDR_W] == raddr[r*ADDR_W +: ADDR_W]))
                    rdata[r*DATA_W +: DATA_W] = wdata[p*DATA_W +: DATA_W];
            end
            if (is_zero(raddr[r*ADDR_W +: ADDR_W]))
                rdata[r*DATA_W +: DATA_W] = '0;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

    decode_regbank_scoreboard #(
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ADDR_W   (ADDR_W),
        .PEND_W   (PEND_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dest   (issue_dest),
        .ruse         (ruse),
        .raddr        (raddr),
        .we           (we),
        .waddr        (waddr),
        .stall        (stall),
        .issue_accept (issue_accept),
        .sb_err       (sb_err)
    );

endmodule
